// File: rtl/write_control_if.sv
// RAM read-port bundle between the write controller and the timing-data RAM.
// Latency: RAM_DATA is valid the cycle after RAM_RD is strobed.
// Backpressure: none; RAM_EMPTY tells the reader there is nothing left to fetch.
//
// Signals:
//   RAM_RD    one-cycle read strobe from the controller
//   RAM_DATA  8-bit read data returned by the RAM
//   RAM_EMPTY RAM has no further data
interface write_control_if;
  logic       RAM_RD;
  logic [7:0] RAM_DATA;
  logic       RAM_EMPTY;

  // Controller side
  modport master (
    output RAM_RD,
    input  RAM_DATA,
    input  RAM_EMPTY
  );

  // RAM side
  modport slave (
    input  RAM_RD,
    output RAM_DATA,
    output RAM_EMPTY
  );
endinterface

// File: rtl/write_control.sv
// Streams timing bytes from RAM into floppy write pulses while holding the write gate.
// Latency: gate rises one cycle after the start event; index events add 3 cycles of sync.
// Backpressure: none; RAM is read one byte at a time only when the previous byte is spent.
//
// Ports:
//   CLK_MASTER, RESET_N       clock, async active-low reset
//   CKE_WRCLK                 write timing tick, decrements the delay counter
//   START, ABORT              begin a write cycle / cancel it immediately
//   FD_INDEX_IN               raw index pulse from the drive (asynchronous)
//   WR_START_*/WR_STOP_*      index qualification masks and skip counts
//   ram                       RAM read port (RAM_RD / RAM_DATA / RAM_EMPTY)
//   FD_WRGATE, FD_WRDATA      registered drive outputs
//   WAITING, WRITING          status
//   END_EMPTY                 sticky: last write ran out of RAM data
module write_control #(
  parameter int unsigned PULSE_WIDTH = 8,
  parameter int unsigned WGATE_HOLD  = 16
) (
  input  logic       CLK_MASTER,
  input  logic       RESET_N,
  input  logic       CKE_WRCLK,
  input  logic       START,
  input  logic       ABORT,
  input  logic       FD_INDEX_IN,
  input  logic [7:0] WR_START_MASK,
  input  logic [7:0] WR_START_NUM,
  input  logic [7:0] WR_STOP_MASK,
  input  logic [7:0] WR_STOP_NUM,
  write_control_if.master ram,
  output logic       FD_WRGATE,
  output logic       FD_WRDATA,
  output logic       WAITING,
  output logic       WRITING,
  output logic       END_EMPTY
);

  localparam int PW_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int TH_W = (WGATE_HOLD > 1) ? $clog2(WGATE_HOLD) : 1;
  localparam logic [PW_W-1:0] PW_LOAD = PW_W'(PULSE_WIDTH - 1);
  localparam logic [TH_W-1:0] TH_LOAD = TH_W'(WGATE_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_FETCH, S_COUNT, S_PULSE, S_TAIL
  } state_t;

  state_t state_q, state_d;

  logic            idx_s1, idx_s2, idx_s3, idx_evt;
  logic [7:0]      scount_q, ecount_q, cnt_q;
  logic            stop_pend_q, pulse_after_q;
  logic [PW_W-1:0] pw_cnt_q;
  logic [TH_W-1:0] tail_cnt_q;
  logic            start_evt, stop_evt, stop_window;
  logic            gate_d, wrdata_d;

  // Only bit 0 of the stop mask qualifies index events.
  logic unused_stop_mask;
  assign unused_stop_mask = ^WR_STOP_MASK[7:1];

  // Index: two-flop synchroniser, then a registered rising-edge detect.
  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_s1  <= 1'b0;
      idx_s2  <= 1'b0;
      idx_s3  <= 1'b0;
      idx_evt <= 1'b0;
    end else begin
      idx_s1  <= FD_INDEX_IN;
      idx_s2  <= idx_s1;
      idx_s3  <= idx_s2;
      idx_evt <= idx_s2 & ~idx_s3;
    end
  end

  // State register and registered drive outputs.
  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      FD_WRGATE <= 1'b0;
      FD_WRDATA <= 1'b0;
    end else begin
      state_q   <= state_d;
      FD_WRGATE <= gate_d;
      FD_WRDATA <= wrdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    start_evt   = (WR_START_MASK == 8'd0) || (WR_START_MASK[0] && idx_evt);
    stop_window = (state_q == S_LOAD) || (state_q == S_FETCH) ||
                  (state_q == S_COUNT) || (state_q == S_PULSE);
    stop_evt    = stop_window && WR_STOP_MASK[0] && idx_evt;
    if (ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (START) state_d = S_WAIT;
        S_WAIT:  if (start_evt && scount_q == 8'd0) state_d = S_LOAD;
        S_LOAD:  state_d = (stop_pend_q || ram.RAM_EMPTY) ? S_TAIL : S_FETCH;
        S_FETCH: state_d = S_COUNT;
        S_COUNT: if (cnt_q == 8'd0) state_d = pulse_after_q ? S_PULSE : S_LOAD;
        S_PULSE: if (pw_cnt_q == '0) state_d = S_LOAD;
        S_TAIL:  if (tail_cnt_q == '0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: gate/data are registered from the next state so they track the
  // state register exactly, and drop the cycle after ABORT.
  always_comb begin
    gate_d     = (state_d == S_LOAD) || (state_d == S_FETCH) || (state_d == S_COUNT) ||
                 (state_d == S_PULSE) || (state_d == S_TAIL);
    wrdata_d   = (state_d == S_PULSE);
    ram.RAM_RD = (state_q == S_LOAD) && !stop_pend_q && !ram.RAM_EMPTY && !ABORT;
    WAITING    = (state_q == S_WAIT);
  end

  assign WRITING = FD_WRGATE;

  // Counters and flags.
  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      scount_q      <= 8'd0;
      ecount_q      <= 8'd0;
      cnt_q         <= 8'd0;
      stop_pend_q   <= 1'b0;
      pulse_after_q <= 1'b0;
      pw_cnt_q      <= '0;
      tail_cnt_q    <= '0;
      END_EMPTY     <= 1'b0;
    end else if (!ABORT) begin
      if (state_q == S_IDLE && START) begin
        scount_q    <= WR_START_NUM;
        ecount_q    <= WR_STOP_NUM;
        stop_pend_q <= 1'b0;
        END_EMPTY   <= 1'b0;
      end
      if (state_q == S_WAIT && start_evt && scount_q != 8'd0)
        scount_q <= scount_q - 8'd1;
      if (state_q == S_LOAD && !stop_pend_q && ram.RAM_EMPTY)
        END_EMPTY <= 1'b1;
      // Bit 7 marks a pure 128-tick carry with no flux transition after it.
      if (state_q == S_FETCH) begin
        if (ram.RAM_DATA[7]) begin
          cnt_q         <= 8'd128;
          pulse_after_q <= 1'b0;
        end else begin
          cnt_q         <= {1'b0, ram.RAM_DATA[6:0]};
          pulse_after_q <= 1'b1;
        end
      end
      if (state_q == S_COUNT && cnt_q != 8'd0 && CKE_WRCLK)
        cnt_q <= cnt_q - 8'd1;
      // A stop only arms a flag; it is acted on at the next LOAD so the
      // byte or pulse in flight always completes.
      if (stop_evt) begin
        if (ecount_q != 8'd0) ecount_q <= ecount_q - 8'd1;
        else                  stop_pend_q <= 1'b1;
      end
      if (state_d == S_PULSE && state_q != S_PULSE) pw_cnt_q <= PW_LOAD;
      else if (state_q == S_PULSE && pw_cnt_q != '0) pw_cnt_q <= pw_cnt_q - 1'b1;
      if (state_d == S_TAIL && state_q != S_TAIL) tail_cnt_q <= TH_LOAD;
      else if (state_q == S_TAIL && tail_cnt_q != '0) tail_cnt_q <= tail_cnt_q - 1'b1;
    end
  end

endmodule
